vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator and pixel colour stage. It sits between the frame-buffer read port and the board's VGA DAC pins. The block derives the pixel rate from the system clock with an internal clock enable and issues frame-buffer read coordinates a configurable number of pixels ahead. It decodes the returned 8-bit colour in one of three modes into RGB444, with sync, RGB and status outputs aligned to each other.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `H_SYNC_POL` / `V_SYNC_POL`, 0 / 0, active level of each sync output
- `CLK_DIV`, 2, `clk` cycles per pixel (≥1)
- `FETCH_LEAD`, 2, pixels by which `v_x` leads display (1 ≤ FETCH_LEAD < H_BP)
- `COORD_W`, 10, width of position counters and coordinates
- `clk  in  1`  system clock (50 MHz)
- `reset  in  1`  synchronous, active-high reset
- `mode  in  2`  colour mode: 0 mono, 1 RGB332, 2 16-colour palette, 3 reserved (decodes as mono)
- `col  in  8`  frame-buffer data for the current pixel
- `v_x  out  COORD_W`  fetch column
- `v_y  out  COORD_W`  fetch row
- `fetch_en  out  1`  `v_x`/`v_y` valid
- `sync_h  out  1`  horizontal sync
- `sync_v  out  1`  vertical sync
- `r`, `g`, `b`  `out  4`  colour outputs
- `vblank  out  1`  high while the registered output line is outside the active area
- `line_start  out  1`  one-`clk` pulse when the horizontal position wraps to 0
- `frame_start  out  1`  one-`clk` pulse when the position wraps to (0,0)

## Operation
- Pixel enable `pix_ce`: a divider counts 0..CLK_DIV-1, and `pix_ce` is asserted when the count is CLK_DIV-1. With CLK_DIV=1, `pix_ce` is always 1.
- Horizontal and vertical positions advance only on `pix_ce`.
- Horizontal order: back porch [0, H_BP), active [H_BP, H_BP+H_ACTIVE), front porch, then sync [H_TOTAL-H_SYNC, H_TOTAL). The vertical axis uses the same order.
- At the last pixel, h wraps to 0. At the last pixel of the last line, v also wraps to 0.
- Fetch window: h+FETCH_LEAD is in the active range and v is active. Inside the window, `fetch_en`=1, `v_x`=h+FETCH_LEAD−H_BP, `v_y`=v−V_BP. Outside it, all three are 0. Fetch outputs are combinational from the counters.
- Display: when h and v are active, colour is decoded from `col`. Otherwise the colour is 0.
- Colour decode by mode:
  - Mono: `col`≠0 gives 15/15/15, otherwise 0.
  - RGB332: r={c[7:5],c[7]}, g={c[4:2],c[4]}, b={c[1:0],c[1:0]}.
  - Palette: index=c[3:0]. Each component is (bit?10:0)+(c[3]?5:0), where r=c[2], g=c[1], b=c[0].
- `mode` is latched into an internal register only at the `pix_ce` that wraps to (0,0), and on reset. A mid-frame change takes effect from the next frame.

## Timing
- `sync_h`, `sync_v`, `r/g/b` and `vblank` are registered and update on `pix_ce`. They reflect the position that held before the edge, so all four stay mutually aligned one pixel slot behind the counters.
- `col` for column x must be valid while h=H_BP+x. Memory read latency up to FETCH_LEAD pixel slots is tolerated.
- `line_start` and `frame_start` are registered and high for exactly one `clk`, on the edge after the wrapping `pix_ce`.
- Reset values:
  - h, v and the divider are 0.
  - `sync_h`=!H_SYNC_POL and `sync_v`=!V_SYNC_POL.
  - `r/g/b`=0, `vblank`=0, pulses=0, latched mode=`mode`.
  - `v_x/v_y/fetch_en` follow the reset counters, so they are 0.
- Reset asserted mid-frame restarts the raster on the next `clk` edge. No partial line or sync completes.
- At the default parameters: line = 800 pixels = 1600 `clk`, and frame = 525 lines = 840000 `clk`.

## Configuration
- `VGA_TESTPAT_EN` defined adds input port `testpat` (1 bit).
  - While `testpat`=1, `col` is ignored and the active area shows 8 vertical bars, each H_ACTIVE/8 wide.
  - Bar k is palette colour k, regardless of `mode`.
  - `v_x/fetch_en` behave unchanged.
- Not defined: no `testpat` port, and `col` is always decoded.

## Structure
- Package `vga_pkg` holds:
  - the `mode` encoding constants;
  - the 16-entry palette function;
  - the default 640×480@60 timing constants.
- Sub-module `vga_pixel_decode` is the combinational decode of mode, `col` and display into r/g/b. The test-pattern mux sits in front of it.

## Test plan
- Reset, defaults, `mode`=0:
  - `sync_h` low for 192 `clk` every 1600 `clk`;
  - `sync_v` low for 3200 `clk` every 840000 `clk`;
  - `frame_start` pulses exactly once per 840000 `clk`.
- Fetch lead: first `fetch_en` of active line 0 occurs at h=46 with `v_x`=0, `v_y`=0. The last occurs at h=685 with `v_x`=639. `fetch_en`=0 during v<33.
- Modes:
  - `mode`=1, `col`=8'hE0 → r=15, g=0, b=0.
  - `col`=8'h1C → g=15.
  - `mode`=2, `col`=4 → r=10, g=0, b=0.
  - `col`=8 → r=5, g=5, b=5.
  - `col`=15 → r=15, g=15, b=15.
- Switching `mode` 0→2 mid-frame keeps mono decode until the next `frame_start`, then palette decode applies.
- CLK_DIV=1, H_ACTIVE=16 with small porches: the line period equals H_TOTAL `clk`, and colour is 0 outside active.
- Reset asserted at v=200 for one `clk`: the next edge gives h=v=0 and sync outputs inactive. The following frame timing matches the first test.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: colour-mode encoding, RGB444 pixel type, the 16-colour palette
// and the default 640x480@60 timing constants for vga_timing_gen.
package vga_pkg;

  // Colour decode modes as driven on the 'mode' input
  typedef enum logic [1:0] {
    MODE_MONO   = 2'd0,
    MODE_RGB332 = 2'd1,
    MODE_PAL16  = 2'd2,
    MODE_RSVD   = 2'd3   // decodes as mono
  } mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Default 640x480@60 raster with a 25 MHz pixel rate from a 50 MHz clock
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_FETCH_LEAD = 2;
  localparam int DEF_COORD_W    = 10;

  // 16-colour palette: idx[2:0] switch R/G/B at weight 10, idx[3] adds 5
  // to every component (so index 8 is dark grey and 15 is full white).
  function automatic rgb444_t palette16(input logic [3:0] idx);
    rgb444_t    c;
    logic [3:0] bright;
    bright = idx[3] ? 4'd5 : 4'd0;
    c.r = (idx[2] ? 4'd10 : 4'd0) + bright;
    c.g = (idx[1] ? 4'd10 : 4'd0) + bright;
    c.b = (idx[0] ? 4'd10 : 4'd0) + bright;
    return c;
  endfunction

endpackage

// File: rtl/vga_pixel_decode.sv
// vga_pixel_decode: combinational decode of one 8-bit frame-buffer value
// into RGB444 according to the colour mode. Outputs are forced to black
// whenever the pixel lies outside the display area.
module vga_pixel_decode
  import vga_pkg::*;
(
  input  mode_e      mode,
  input  logic [7:0] col,
  input  logic       display,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  rgb444_t pal;

  assign pal = palette16(col[3:0]);

  // Select the decoded colour for the current mode, black when blanked
  always_comb begin
    // NOTE: every output is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    r = '0;
    g = '0;
    b = '0;
    if (display) begin
      case (mode)
        MODE_RGB332: begin
          // Replicate the top bits so full-scale codes reach 15
          r = {col[7:5], col[7]};
          g = {col[4:2], col[4]};
          b = {col[1:0], col[1:0]};
        end
        MODE_PAL16: begin
          r = pal.r;
          g = pal.g;
          b = pal.b;
        end
        default: begin
          // Mono and the reserved code: any non-zero value is white
          if (col != 8'd0) begin
            r = 4'hF;
            g = 4'hF;
            b = 4'hF;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator. Derives the pixel rate
// from clk with a clock enable, issues frame-buffer fetch coordinates
// FETCH_LEAD pixels ahead of display, and registers sync, colour and blanking
// so they leave the block mutually aligned.
// Optional feature: define VGA_TESTPAT_EN to add a 'testpat' input that
// replaces the frame-buffer colour with eight vertical palette bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FETCH_LEAD = DEF_FETCH_LEAD,
  parameter int COORD_W    = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [7:0]         col,
`ifdef VGA_TESTPAT_EN
  input  logic               testpat,
`endif
  output logic [COORD_W-1:0] v_x,
  output logic [COORD_W-1:0] v_y,
  output logic               fetch_en,
  output logic               sync_h,
  output logic               sync_v,
  output logic [3:0]         r,
  output logic [3:0]         g,
  output logic [3:0]         b,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start
);

  // Raster geometry. Order on both axes: back porch, active, front porch, sync.
  localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP + V_SYNC;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW      = COORD_W + 1;   // room for h + FETCH_LEAD

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_LO  = COORD_W'(H_BP);
  localparam logic [COORD_W-1:0] H_ACT_HI  = COORD_W'(H_BP + H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_LO  = COORD_W'(V_BP);
  localparam logic [COORD_W-1:0] V_ACT_HI  = COORD_W'(V_BP + V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_TOTAL - H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_TOTAL - V_SYNC);
  localparam logic [LW-1:0]      LEAD      = LW'(FETCH_LEAD);
  localparam logic [LW-1:0]      LEAD_LO   = LW'(H_BP);
  localparam logic [LW-1:0]      LEAD_HI   = LW'(H_BP + H_ACTIVE);
  // FETCH_LEAD < H_BP, so this offset is negative and wraps modulo 2^COORD_W
  localparam logic [COORD_W-1:0] X_OFFSET  = COORD_W'(FETCH_LEAD - H_BP);

  logic [DIV_W-1:0]   div_cnt;
  logic               pix_ce;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_last;
  logic               v_last;
  logic               frame_wrap;
  logic               h_active;
  logic               v_active;
  logic               display;
  logic               h_in_sync;
  logic               v_in_sync;
  logic [LW-1:0]      h_lead;
  logic               fetch_win;
  mode_e              mode_q;
  mode_e              dec_mode;
  logic [7:0]         dec_col;
  logic [3:0]         dec_r;
  logic [3:0]         dec_g;
  logic [3:0]         dec_b;

  // ---------------------------------------------------------------------
  // Pixel clock enable
  // ---------------------------------------------------------------------
  assign pix_ce = (div_cnt == DIV_LAST);

  // Divide clk down to the pixel rate; pix_ce marks the last clk of a slot
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the update order cannot matter.
    if (reset) begin
      div_cnt <= '0;
    end else if (pix_ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Raster position
  // ---------------------------------------------------------------------
  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_wrap = pix_ce && h_last && v_last;

  // Advance h once per pixel slot; v steps when h wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  assign h_active  = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
  assign v_active  = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
  assign display   = h_active && v_active;
  assign h_in_sync = (h_cnt >= H_SYNC_LO);
  assign v_in_sync = (v_cnt >= V_SYNC_LO);

  // ---------------------------------------------------------------------
  // Frame-buffer fetch: combinational from the counters, FETCH_LEAD ahead
  // ---------------------------------------------------------------------
  assign h_lead    = {1'b0, h_cnt} + LEAD;
  assign fetch_win = (h_lead >= LEAD_LO) && (h_lead < LEAD_HI) && v_active;
  assign fetch_en  = fetch_win;
  assign v_x       = fetch_win ? (h_cnt + X_OFFSET) : '0;
  assign v_y       = fetch_win ? (v_cnt - V_ACT_LO) : '0;

  // ---------------------------------------------------------------------
  // Colour mode: held for the whole frame, reloaded at the (0,0) wrap
  // ---------------------------------------------------------------------
  // Latch the requested mode on reset and at each frame boundary only
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= mode_e'(mode);
    end else if (frame_wrap) begin
      mode_q <= mode_e'(mode);
    end
  end

`ifdef VGA_TESTPAT_EN
  // Eight equal bars across the active width; any remainder columns from a
  // width not divisible by 8 are folded into the last bar.
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [COORD_W-1:0] h_rel;
  logic [COORD_W-1:0] bar_num;
  logic [2:0]         bar_idx;

  assign h_rel    = h_cnt - H_ACT_LO;
  assign bar_num  = h_rel / COORD_W'(BAR_W);
  assign bar_idx  = (bar_num > COORD_W'(7)) ? 3'd7 : bar_num[2:0];
  assign dec_mode = testpat ? MODE_PAL16 : mode_q;
  assign dec_col  = testpat ? {5'd0, bar_idx} : col;
`else
  assign dec_mode = mode_q;
  assign dec_col  = col;
`endif

  vga_pixel_decode u_decode (
    .mode    (dec_mode),
    .col     (dec_col),
    .display (display),
    .r       (dec_r),
    .g       (dec_g),
    .b       (dec_b)
  );

  // ---------------------------------------------------------------------
  // Output stage: everything visible on the DAC pins moves together
  // ---------------------------------------------------------------------
  // Register sync, colour and blanking for the slot that is just ending
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_h <= ~H_SYNC_POL;
      sync_v <= ~V_SYNC_POL;
      r      <= '0;
      g      <= '0;
      b      <= '0;
      vblank <= 1'b0;
    end else if (pix_ce) begin
      sync_h <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
      sync_v <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
      r      <= dec_r;
      g      <= dec_g;
      b      <= dec_b;
      vblank <= ~v_active;
    end
  end

  // One-clk strobes on the edge where the position wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_last;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small-raster instances (CLK_DIV=2 with low-active
// syncs, CLK_DIV=1 with high-active syncs) compared every clk against a
// behavioural model that derives position from elapsed pixel slots, plus
// directed literal checks of timing, fetch window and colour decode.
module tb_vga_timing_gen;

  localparam int CW = 10;

  // Instance A
  localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 4;
  localparam int A_VA = 4,  A_VFP = 1, A_VS = 2, A_VBP = 3;
  localparam int A_D  = 2,  A_FL  = 2, A_HPOL = 0, A_VPOL = 0;
  localparam int A_HT = 25, A_VT = 10;              // totals
  localparam int A_FRAME = A_HT * A_VT * A_D;        // 500 clk
  // clk after frame_start at which the outputs show pixel (A_HBP+5, A_VBP)
  localparam int A_PIX_OFF = (A_VBP * A_HT + A_HBP + 6) * A_D;

  // Instance B
  localparam int B_HA = 16, B_HFP = 1, B_HS = 2, B_HBP = 3;
  localparam int B_VA = 3,  B_VFP = 1, B_VS = 1, B_VBP = 2;
  localparam int B_D  = 1,  B_FL  = 2, B_HPOL = 1, B_VPOL = 1;
  localparam int B_HT = 22;

  localparam int SIG_A_FS = 0, SIG_B_LS = 1, SIG_A_FE = 2;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, d, fl, hpol, vpol;
  } cfg_t;

  typedef struct {
    int vx, vy, fe, sh, sv, r, g, b, vb, ls, fs;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] col;

  logic [CW-1:0] a_vx, a_vy, b_vx, b_vy;
  logic          a_fe, a_sh, a_sv, a_vb, a_ls, a_fs;
  logic          b_fe, b_sh, b_sv, b_vb, b_ls, b_fs;
  logic [3:0]    a_r, a_g, a_b, b_r, b_g, b_b;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .CLK_DIV(A_D), .FETCH_LEAD(A_FL), .COORD_W(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .col(col),
`ifdef VGA_TESTPAT_EN
    .testpat(1'b0),
`endif
    .v_x(a_vx), .v_y(a_vy), .fetch_en(a_fe), .sync_h(a_sh), .sync_v(a_sv),
    .r(a_r), .g(a_g), .b(a_b), .vblank(a_vb),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
    .CLK_DIV(B_D), .FETCH_LEAD(B_FL), .COORD_W(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .col(col),
`ifdef VGA_TESTPAT_EN
    .testpat(1'b0),
`endif
    .v_x(b_vx), .v_y(b_vy), .fetch_en(b_fe), .sync_h(b_sh), .sync_v(b_sv),
    .r(b_r), .g(b_g), .b(b_b), .vblank(b_vb),
    .line_start(b_ls), .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------
  task automatic check_int(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("vx=%0d vy=%0d fe=%0d hs=%0d vs=%0d rgb=%0d/%0d/%0d vb=%0d ls=%0d fs=%0d",
                     o.vx, o.vy, o.fe, o.sh, o.sv, o.r, o.g, o.b, o.vb, o.ls, o.fs);
  endfunction

  function automatic bit same(input obs_t x, input obs_t y);
    return x.vx == y.vx && x.vy == y.vy && x.fe == y.fe && x.sh == y.sh &&
           x.sv == y.sv && x.r == y.r && x.g == y.g && x.b == y.b &&
           x.vb == y.vb && x.ls == y.ls && x.fs == y.fs;
  endfunction

  task automatic check_obs(input string nm, input obs_t act, input obs_t want);
    checks++;
    if (!same(act, want)) begin
      failures++;
      $display("FAIL %s t=%0t got {%s} expected {%s}", nm, $time, fmt(act), fmt(want));
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    if (i == 0) begin
      c.ha = A_HA; c.hfp = A_HFP; c.hs = A_HS; c.hbp = A_HBP;
      c.va = A_VA; c.vfp = A_VFP; c.vs = A_VS; c.vbp = A_VBP;
      c.d = A_D; c.fl = A_FL; c.hpol = A_HPOL; c.vpol = A_VPOL;
    end else begin
      c.ha = B_HA; c.hfp = B_HFP; c.hs = B_HS; c.hbp = B_HBP;
      c.va = B_VA; c.vfp = B_VFP; c.vs = B_VS; c.vbp = B_VBP;
      c.d = B_D; c.fl = B_FL; c.hpol = B_HPOL; c.vpol = B_VPOL;
    end
    return c;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0) begin
      o.vx = int'(a_vx); o.vy = int'(a_vy); o.fe = int'(a_fe);
      o.sh = int'(a_sh); o.sv = int'(a_sv);
      o.r = int'(a_r); o.g = int'(a_g); o.b = int'(a_b);
      o.vb = int'(a_vb); o.ls = int'(a_ls); o.fs = int'(a_fs);
    end else begin
      o.vx = int'(b_vx); o.vy = int'(b_vy); o.fe = int'(b_fe);
      o.sh = int'(b_sh); o.sv = int'(b_sv);
      o.r = int'(b_r); o.g = int'(b_g); o.b = int'(b_b);
      o.vb = int'(b_vb); o.ls = int'(b_ls); o.fs = int'(b_fs);
    end
    return o;
  endfunction

  // Colour rules written as arithmetic on the byte value
  task automatic ref_colour(input int md, input int c, output int cr, output int cg, output int cb);
    int base;
    if (md == 1) begin
      cr = (c >> 5) * 2 + (c >> 7);
      cg = ((c >> 2) % 8) * 2 + ((c >> 4) % 2);
      cb = (c % 4) * 5;
    end else if (md == 2) begin
      base = ((c >> 3) % 2) * 5;
      cr = ((c >> 2) % 2) * 10 + base;
      cg = ((c >> 1) % 2) * 10 + base;
      cb = (c % 2) * 10 + base;
    end else begin
      cr = (c != 0) ? 15 : 0;
      cg = cr;
      cb = cr;
    end
  endtask

  int   mk[2];     // clk edges since the last reset edge
  int   mlat[2];   // mode in force for the current frame
  obs_t mreg[2];   // expected registered outputs
  bit   model_on = 1'b0;

  task automatic model_step(input int i);
    cfg_t c;
    int ht, vt, n, h, v, cr, cg, cb;
    bit hact, vact;
    c  = get_cfg(i);
    ht = c.hbp + c.ha + c.hfp + c.hs;
    vt = c.vbp + c.va + c.vfp + c.vs;
    if (reset) begin
      mk[i] = 0;
      mlat[i] = int'(mode);
      mreg[i].sh = 1 - c.hpol; mreg[i].sv = 1 - c.vpol;
      mreg[i].r = 0; mreg[i].g = 0; mreg[i].b = 0;
      mreg[i].vb = 0; mreg[i].ls = 0; mreg[i].fs = 0;
    end else begin
      n = mk[i] / c.d;
      h = n % ht;
      v = (n / ht) % vt;
      mreg[i].ls = 0;
      mreg[i].fs = 0;
      if (mk[i] % c.d == c.d - 1) begin
        hact = (h >= c.hbp) && (h < c.hbp + c.ha);
        vact = (v >= c.vbp) && (v < c.vbp + c.va);
        mreg[i].sh = (h >= ht - c.hs) ? c.hpol : 1 - c.hpol;
        mreg[i].sv = (v >= vt - c.vs) ? c.vpol : 1 - c.vpol;
        mreg[i].vb = vact ? 0 : 1;
        if (hact && vact) ref_colour(mlat[i], int'(col), cr, cg, cb);
        else begin cr = 0; cg = 0; cb = 0; end
        mreg[i].r = cr; mreg[i].g = cg; mreg[i].b = cb;
        if (h == ht - 1) mreg[i].ls = 1;
        if (h == ht - 1 && v == vt - 1) begin
          mreg[i].fs = 1;
          mlat[i] = int'(mode);
        end
      end
      mk[i]++;
    end
  endtask

  function automatic obs_t expect_obs(input int i);
    cfg_t c;
    obs_t e;
    int ht, vt, n, h, v;
    c  = get_cfg(i);
    ht = c.hbp + c.ha + c.hfp + c.hs;
    vt = c.vbp + c.va + c.vfp + c.vs;
    n  = mk[i] / c.d;
    h  = n % ht;
    v  = (n / ht) % vt;
    e  = mreg[i];
    if (h + c.fl >= c.hbp && h + c.fl < c.hbp + c.ha && v >= c.vbp && v < c.vbp + c.va) begin
      e.fe = 1; e.vx = h + c.fl - c.hbp; e.vy = v - c.vbp;
    end else begin
      e.fe = 0; e.vx = 0; e.vy = 0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    model_on = 1'b1;
  end

  // Compare both instances against the model every clk
  always @(negedge clk) begin
    if (model_on) begin
      check_obs("cycle_a", get_obs(0), expect_obs(0));
      check_obs("cycle_b", get_obs(1), expect_obs(1));
    end
  end

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------
  function automatic bit sig(input int which);
    case (which)
      SIG_A_FS: return a_fs;
      SIG_B_LS: return b_ls;
      SIG_A_FE: return a_fe;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string nm, input int budget, output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      ok = sig(which);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: no event within %0d clk", nm, budget);
    end
  endtask

  task automatic sample_colour(input string nm, input int er, input int eg, input int eb);
    int cyc;
    wait_for(SIG_A_FS, {nm, "_wait"}, 2 * A_FRAME, cyc);
    repeat (A_PIX_OFF) @(negedge clk);
    check_int({nm, "_r"}, int'(a_r), er);
    check_int({nm, "_g"}, int'(a_g), eg);
    check_int({nm, "_b"}, int'(a_b), eb);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int cyc, hs_lo, vs_lo, fs_n, ls_n, hi, last_vx;

    reset = 1'b1;
    mode  = 2'd0;
    col   = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state: syncs inactive, colour and strobes low, no fetch
    check_int("rst_a_sync_h", int'(a_sh), 1);
    check_int("rst_a_sync_v", int'(a_sv), 1);
    check_int("rst_b_sync_h", int'(b_sh), 0);
    check_int("rst_b_sync_v", int'(b_sv), 0);
    check_int("rst_a_fetch",  int'(a_fe), 0);
    check_int("rst_a_r",      int'(a_r),  0);
    check_int("rst_a_vblank", int'(a_vb), 0);
    reset = 1'b0;

    // Sync widths and strobe counts over one whole frame of instance A
    col = 8'hFF;
    wait_for(SIG_A_FS, "frame_wait", 2 * A_FRAME, cyc);
    check_int("first_frame_period", cyc, A_FRAME);
    hs_lo = 0; vs_lo = 0; fs_n = 0; ls_n = 0;
    for (int t = 0; t < A_FRAME; t++) begin
      @(negedge clk);
      if (!a_sh) hs_lo++;
      if (!a_sv) vs_lo++;
      if (a_fs)  fs_n++;
      if (a_ls)  ls_n++;
    end
    check_int("hsync_low_clk_per_frame", hs_lo, A_HS * A_D * A_VT);
    check_int("vsync_low_clk_per_frame", vs_lo, A_VS * A_HT * A_D);
    check_int("frame_start_per_frame",   fs_n, 1);
    check_int("line_start_per_frame",    ls_n, A_VT);

    // Line period with CLK_DIV=1 equals the line total in clk
    wait_for(SIG_B_LS, "b_line_wait", 4 * B_HT, cyc);
    wait_for(SIG_B_LS, "b_line_period", 4 * B_HT, cyc);
    check_int("b_line_period", cyc, B_HT);

    // Fetch window: opens FETCH_LEAD pixels before the first active column
    wait_for(SIG_A_FS, "fetch_fs_wait", 2 * A_FRAME, cyc);
    wait_for(SIG_A_FE, "fetch_open", A_FRAME, cyc);
    check_int("fetch_first_clk", cyc, (A_VBP * A_HT + A_HBP - A_FL) * A_D);
    check_int("fetch_first_vx", int'(a_vx), 0);
    check_int("fetch_first_vy", int'(a_vy), 0);
    hi = 0;
    last_vx = int'(a_vx);
    while (a_fe && hi < 200) begin
      last_vx = int'(a_vx);
      @(negedge clk);
      hi++;
    end
    check_int("fetch_high_clk", hi, A_HA * A_D);
    check_int("fetch_last_vx", last_vx, A_HA - 1);

    // Colour decode literals
    mode = 2'd1; col = 8'hE0;
    sample_colour("rgb332_e0", 15, 0, 0);
    col = 8'h1C;
    sample_colour("rgb332_1c", 0, 15, 0);
    mode = 2'd2; col = 8'd4;
    sample_colour("pal_4", 10, 0, 0);
    col = 8'd8;
    sample_colour("pal_8", 5, 5, 5);
    col = 8'd15;
    sample_colour("pal_15", 15, 15, 15);

    // Mid-frame mode switch is deferred to the next frame
    mode = 2'd0; col = 8'd4;
    sample_colour("mono_4", 15, 15, 15);
    mode = 2'd2;
    repeat (A_HT * A_D) @(negedge clk);
    check_int("mode_hold_r", int'(a_r), 15);
    check_int("mode_hold_b", int'(a_b), 15);
    sample_colour("mode_next_frame", 10, 0, 0);

    // One-clk reset in the middle of a frame restarts the raster
    wait_for(SIG_A_FS, "rst_fs_wait", 2 * A_FRAME, cyc);
    repeat (5 * A_HT * A_D + 14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_int("midrst_a_sync_h", int'(a_sh), 1);
    check_int("midrst_a_sync_v", int'(a_sv), 1);
    check_int("midrst_b_sync_h", int'(b_sh), 0);
    check_int("midrst_a_fetch",  int'(a_fe), 0);
    check_int("midrst_a_r",      int'(a_r),  0);
    reset = 1'b0;
    wait_for(SIG_A_FS, "midrst_frame", 2 * A_FRAME, cyc);
    check_int("midrst_frame_period", cyc, A_FRAME);

    // Randomised traffic checked by the per-cycle model comparison
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      col = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 399) == 0) mode = 2'($urandom);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 4999) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
